// File: rtl/mem_responder_pkg.sv
// mem_pkg: shared types for the memory responder and the control block.
// Holds FSM states, op encodings, default widths and an address-width helper.
package mem_pkg;

  localparam int BITS_DEF  = 8;
  localparam int DEPTH_DEF = 256;
  localparam int WAIT_DEF  = 2;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  function automatic int addr_w(int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/ack bus between the CPU core and the responder.
// master drives req/we/addr/wdata; slave drives ready/ack/rdata/err.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int BITS = BITS_DEF
) ();

  logic            req;
  logic            we;
  logic [BITS-1:0] addr;
  logic [BITS-1:0] wdata;
  logic            ready;
  logic            ack;
  logic [BITS-1:0] rdata;
  logic            err;

  modport master (
    output req, we, addr, wdata,
    input  ready, ack, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, ack, rdata, err
  );

endinterface

// File: rtl/mem_responder_array.sv
// mem_array: single-port synchronous RAM, DEPTH x BITS, registered read.
// Ports: clk, we, addr, wdata, rdata. No reset; contents survive reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = addr_w(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [BITS-1:0] wdata,
  output logic [BITS-1:0] rdata
);

  logic [BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: one-at-a-time read/write responder with single-cycle ack.
// Ports: i_clk, i_rst_n, bus (slave). Read wait states: MEM_WAIT_STATES_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int BITS        = BITS_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WAIT_CYCLES = WAIT_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  mem_responder_if.slave bus
);

  localparam int AW = addr_w(DEPTH);
  localparam logic [BITS:0] LIMIT = (BITS+1)'(DEPTH);

  state_t          state;
  logic [BITS-1:0] addr_q;
  logic [BITS-1:0] wdata_q;
  logic            oor_q;
  logic            oor_in;
  logic [BITS-1:0] arr_addr;
  logic [BITS-1:0] arr_rdata;
  logic            arr_we;
  logic            accept;

  assign accept = bus.req && bus.ready;
  // Unsigned compare with one spare bit, so DEPTH == 2**BITS never errs.
  assign oor_in = {1'b0, bus.addr} >= LIMIT;

  // The array sees the live address while idle, so the accept edge
  // already launches the read and its data is ready during READ.
  assign arr_addr = (state == IDLE) ? bus.addr : addr_q;
  assign arr_we   = (state == WRITE) && !oor_q;

  logic unused_addr;
  assign unused_addr = ^arr_addr;

  mem_array #(
    .BITS  (BITS),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (i_clk),
    .we    (arr_we),
    .addr  (arr_addr[AW-1:0]),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

`ifdef MEM_WAIT_STATES_EN
  logic [3:0] cnt_q;
`else
  logic [3:0] unused_wait;
  assign unused_wait = 4'(WAIT_CYCLES);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      bus.ready <= 1'b1;
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
      bus.err   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      oor_q     <= 1'b0;
`ifdef MEM_WAIT_STATES_EN
      cnt_q     <= '0;
`endif
    end else begin
      bus.ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            addr_q    <= bus.addr;
            wdata_q   <= bus.wdata;
            oor_q     <= oor_in;
            bus.ready <= 1'b0;
            bus.err   <= 1'b0;
            state     <= (bus.we == OP_WRITE)
                         ? WRITE : READ;
`ifdef MEM_WAIT_STATES_EN
            cnt_q     <= 4'(WAIT_CYCLES);
`endif
          end
        end
        WRITE: begin
          state     <= RESP;
          bus.ack   <= 1'b1;
          bus.err   <= oor_q;
          bus.rdata <= '0;
        end
        READ: begin
          bus.rdata <= oor_q ? '0 : arr_rdata;
`ifdef MEM_WAIT_STATES_EN
          if (cnt_q != '0) begin
            state <= WAIT;
          end else begin
            state   <= RESP;
            bus.ack <= 1'b1;
            bus.err <= oor_q;
          end
`else
          state   <= RESP;
          bus.ack <= 1'b1;
          bus.err <= oor_q;
`endif
        end
`ifdef MEM_WAIT_STATES_EN
        WAIT: begin
          if (cnt_q <= 4'd1) begin
            cnt_q   <= '0;
            state   <= RESP;
            bus.ack <= 1'b1;
            bus.err <= oor_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`endif
        RESP: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
          bus.err   <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
          bus.ack   <= 1'b0;
          bus.rdata <= '0;
          bus.err   <= 1'b0;
`ifdef MEM_WAIT_STATES_EN
          cnt_q     <= '0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (DEPTH=200).
// Stimulus pushes expected acks; a negedge monitor pops and compares.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int W = 2;
`ifdef MEM_WAIT_STATES_EN
  localparam int RD_LAT = 2 + W;
`else
  localparam int RD_LAT = 2;
`endif
  localparam int WR_LAT = 2;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic prev_ack = 1'b0;

  exp_t exp_q[$];
  int   acc_q[$];

  mem_responder_if #(.BITS(8)) bus ();

  mem_responder #(
    .BITS        (8),
    .DEPTH       (200),
    .WAIT_CYCLES (W)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic exp_t mk(logic [7:0] r,
                              logic e, int l);
    exp_t x;
    x.rdata = r;
    x.err   = e;
    x.lat   = l;
    return x;
  endfunction

  // Cycle index of the cycle ending at this edge is logged on accept.
  always @(posedge clk) begin
    if (!rst_n) acc_q.delete();
    else if (bus.req && bus.ready) acc_q.push_back(cyc);
    cyc++;
  end

  always @(negedge clk) begin : mon
    exp_t e;
    int   a;
    if (rst_n && bus.ack) begin
      check("ack_gap", 32'(prev_ack), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=1 expected none");
      end else begin
        e = exp_q.pop_front();
        a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
        check("rdata", 32'(bus.rdata), 32'(e.rdata));
        check("err", 32'(bus.err), 32'(e.err));
        check("latency", 32'(cyc - a), 32'(e.lat));
      end
    end
    prev_ack = bus.ack;
  end

  task automatic issue(logic we, logic [7:0] a,
                       logic [7:0] d, exp_t e);
    int n = 0;
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = we;
    bus.addr  = a;
    bus.wdata = d;
    exp_q.push_back(e);
    do begin
      @(posedge clk);
      n++;
    end while (!(bus.ready && bus.req) && n < 20);
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got none expected accept");
    end
  endtask

  task automatic wait_ack(output int at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ack && n < 30);
    at = cyc;
    if (!bus.ack) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got none expected ack");
    end
  endtask

  task automatic op(logic we, logic [7:0] a,
                    logic [7:0] d, exp_t e);
    int t;
    issue(we, a, d, e);
    wait_ack(t);
    bus.req = 1'b0;
  endtask

  initial begin
    int t0, t1, t2, n;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);

    op(1'b1, 8'h10, 8'hA5, mk(8'h00, 1'b0, WR_LAT));
    op(1'b0, 8'h10, 8'h00, mk(8'hA5, 1'b0, RD_LAT));

    issue(1'b1, 8'h00, 8'h11, mk(8'h00, 1'b0, WR_LAT));
    wait_ack(t0);
    issue(1'b1, 8'h01, 8'h22, mk(8'h00, 1'b0, WR_LAT));
    wait_ack(t1);
    issue(1'b1, 8'h02, 8'h33, mk(8'h00, 1'b0, WR_LAT));
    wait_ack(t2);
    bus.req = 1'b0;
    check("b2b_gap1", 32'(t1 - t0), 32'd3);
    check("b2b_gap2", 32'(t2 - t1), 32'd3);
    op(1'b0, 8'h00, 8'h00, mk(8'h11, 1'b0, RD_LAT));
    op(1'b0, 8'h01, 8'h00, mk(8'h22, 1'b0, RD_LAT));
    op(1'b0, 8'h02, 8'h00, mk(8'h33, 1'b0, RD_LAT));

    op(1'b1, 8'h48, 8'h77, mk(8'h00, 1'b0, WR_LAT));
    op(1'b1, 8'hC8, 8'h5A, mk(8'h00, 1'b1, WR_LAT));
    op(1'b0, 8'hC8, 8'h00, mk(8'h00, 1'b1, RD_LAT));
    op(1'b0, 8'h48, 8'h00, mk(8'h77, 1'b0, RD_LAT));
    op(1'b1, 8'hC7, 8'h99, mk(8'h00, 1'b0, WR_LAT));
    op(1'b0, 8'hC7, 8'h00, mk(8'h99, 1'b0, RD_LAT));
    op(1'b0, 8'hFF, 8'h00, mk(8'h00, 1'b1, RD_LAT));

    issue(1'b0, 8'h01, 8'h00, mk(8'h22, 1'b0, RD_LAT));
    @(negedge clk);
    bus.req = 1'b0;
    wait_ack(t0);
    @(negedge clk);
    check("drop_ready", 32'(bus.ready), 32'd1);
    check("drop_ack", 32'(bus.ack), 32'd0);

    issue(1'b0, 8'h10, 8'h00, mk(8'hA5, 1'b0, RD_LAT));
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mrst_ready", 32'(bus.ready), 32'd1);
    check("mrst_ack", 32'(bus.ack), 32'd0);
    repeat (4) @(negedge clk);
    check("mrst_idle", 32'(bus.ready), 32'd1);
    op(1'b0, 8'h10, 8'h00, mk(8'hA5, 1'b0, RD_LAT));

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               exp_q.size());
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
